// File: rtl/wb_buffer_pkg.sv
// rtl/wb_buffer_pkg.sv - shared CPU constants: register index width, opcodes, writeback entry width
package wb_buffer_pkg;

  localparam int REG_WIDTH = 5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  // Writeback entry is packed as {pos, rd, value}.
  function automatic int wb_entry_width(input int sb_width, input int data_width);
    return sb_width + REG_WIDTH + data_width;
  endfunction

endpackage

// File: rtl/wb_fifo_mem.sv
// rtl/wb_fifo_mem.sv - writeback entry storage, two write ports and one asynchronous read port
module wb_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 41,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_a,
  input  logic [AW-1:0]    waddr_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             we_b,
  input  logic [AW-1:0]    waddr_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  // The two write addresses never collide: the top always places port B after port A.
  always_comb begin
    mem_d = mem_q;
    if (we_a) mem_d[waddr_a] = wdata_a;
    if (we_b) mem_d[waddr_b] = wdata_b;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_buffer.sv
// rtl/wb_buffer.sv - writeback buffer merging ALU and load/store results into one commit stream
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int SB_SIZE_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [SB_SIZE_WIDTH-1:0] alu_pos,
  input  logic [REG_WIDTH-1:0]     alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_value,
  input  logic                     ls_valid,
  input  logic [SB_SIZE_WIDTH-1:0] ls_pos,
  input  logic [REG_WIDTH-1:0]     ls_rd,
  input  logic [DATA_WIDTH-1:0]    ls_value,
  output logic                     out_valid,
  output logic [SB_SIZE_WIDTH-1:0] out_pos,
  output logic [REG_WIDTH-1:0]     out_rd,
  output logic [DATA_WIDTH-1:0]    out_value,
  input  logic                     out_ready,
  output logic                     stall,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = wb_entry_width(SB_SIZE_WIDTH, DATA_WIDTH);

  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          pop, alu_acc, ls_acc;
  logic [AW+1:0] free;
  logic [AW-1:0] ls_addr;
  logic [EW-1:0] alu_entry, ls_entry, head_entry;

  always_comb begin
    pop     = (count_q != '0) && out_ready;
    free    = (AW+2)'(DEPTH) - {1'b0, count_q} + (AW+2)'(pop);
    // ALU claims the first free slot, so LS is the one dropped when only one remains.
    alu_acc = alu_valid && (free != '0);
    ls_acc  = ls_valid && (free > (alu_acc ? (AW+2)'(1) : (AW+2)'(0)));
    ls_addr = tail_q + AW'(alu_acc);

    head_d     = head_q + AW'(pop);
    tail_d     = tail_q + AW'(alu_acc) + AW'(ls_acc);
    count_d    = count_q + (AW+1)'(alu_acc) + (AW+1)'(ls_acc) - (AW+1)'(pop);
    overflow_d = overflow_q | (alu_valid & ~alu_acc) | (ls_valid & ~ls_acc);

    // Writes to x0 still retire their scoreboard slot but carry no data.
    alu_entry = {alu_pos, alu_rd, (alu_rd == '0) ? {DATA_WIDTH{1'b0}} : alu_value};
    ls_entry  = {ls_pos, ls_rd, (ls_rd == '0) ? {DATA_WIDTH{1'b0}} : ls_value};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  wb_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_a    (alu_acc & ~rst),
    .waddr_a (tail_q),
    .wdata_a (alu_entry),
    .we_b    (ls_acc & ~rst),
    .waddr_b (ls_addr),
    .wdata_b (ls_entry),
    .raddr   (head_q),
    .rdata   (head_entry)
  );

  assign out_valid = (count_q != '0);
  assign {out_pos, out_rd, out_value} = out_valid ? head_entry : '0;
  // Two slots of headroom absorb results already in flight when issue stops.
  assign stall    = (count_q >= (AW+1)'(DEPTH - 2));
  assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_buffer.sv
// tb/tb_wb_buffer.sv - table-driven directed bench for wb_buffer
module tb_wb_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ls_valid, out_ready;
  logic [3:0]  alu_pos, ls_pos, out_pos;
  logic [4:0]  alu_rd, ls_rd, out_rd;
  logic [31:0] alu_value, ls_value, out_value;
  logic        out_valid, stall, overflow;

  always #5 clk = ~clk;

  wb_buffer #(
    .SB_SIZE_WIDTH (4),
    .DATA_WIDTH    (32),
    .DEPTH         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_pos   (alu_pos),
    .alu_rd    (alu_rd),
    .alu_value (alu_value),
    .ls_valid  (ls_valid),
    .ls_pos    (ls_pos),
    .ls_rd     (ls_rd),
    .ls_value  (ls_value),
    .out_valid (out_valid),
    .out_pos   (out_pos),
    .out_rd    (out_rd),
    .out_value (out_value),
    .out_ready (out_ready),
    .stall     (stall),
    .overflow  (overflow)
  );

  typedef struct {
    logic        rst;
    logic        av;
    logic [3:0]  ap;
    logic [4:0]  ar;
    logic [31:0] aval;
    logic        lv;
    logic [3:0]  lp;
    logic [4:0]  lr;
    logic [31:0] lval;
    logic        rdy;
    logic        ev;
    logic [3:0]  ep;
    logic [4:0]  er;
    logic [31:0] evl;
    logic        es;
    logic        eo;
    string       nm;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic av, input logic [3:0] ap, input logic [4:0] ar,
                     input logic [31:0] aval, input logic lv, input logic [3:0] lp,
                     input logic [4:0] lr, input logic [31:0] lval, input logic rdy,
                     input logic ev, input logic [3:0] ep, input logic [4:0] er,
                     input logic [31:0] evl, input logic es, input logic eo, input string nm);
    vec_t v;
    v.rst = r;  v.av = av; v.ap = ap; v.ar = ar; v.aval = aval;
    v.lv = lv;  v.lp = lp; v.lr = lr; v.lval = lval; v.rdy = rdy;
    v.ev = ev;  v.ep = ep; v.er = er; v.evl = evl; v.es = es; v.eo = eo; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, step, act, exp);
    end
  endtask

  // Entry s of the wrap sequence: pos s mod 16, rd (s mod 31)+1, value 0x200+s.
  function automatic logic [3:0]  wp(input int s); return 4'(s % 16); endfunction
  function automatic logic [4:0]  wr(input int s); return 5'((s % 31) + 1); endfunction
  function automatic logic [31:0] wv(input int s); return 32'(32'h200 + s); endfunction

  initial begin
    rst = 1'b1; alu_valid = 1'b0; ls_valid = 1'b0; out_ready = 1'b0;
    alu_pos = '0; alu_rd = '0; alu_value = '0; ls_pos = '0; ls_rd = '0; ls_value = '0;

    // Reset state
    add(1, 0,0,0,0, 0,0,0,0, 0,  0,0,0,0, 0,0, "reset");

    // Single ALU push then drain
    add(0, 1,3,5,32'h1234, 0,0,0,0, 1,  1,3,5,32'h1234, 0,0, "single_push");
    add(0, 0,0,0,0,        0,0,0,0, 1,  0,0,0,0,        0,0, "single_pop");

    // Same-cycle ALU+LS: ALU first
    add(0, 1,1,1,32'hA, 1,2,2,32'hB, 0,  1,1,1,32'hA, 0,0, "dual_push");
    add(0, 0,0,0,0,     0,0,0,0,     1,  1,2,2,32'hB, 0,0, "dual_pop1");
    add(0, 0,0,0,0,     0,0,0,0,     1,  0,0,0,0,     0,0, "dual_pop2");

    // LS-only push
    add(0, 0,0,0,0, 1,4,3,32'h77, 0,  1,4,3,32'h77, 0,0, "ls_push");
    add(0, 0,0,0,0, 0,0,0,0,      1,  0,0,0,0,      0,0, "ls_pop");

    // rd=0 forces value to zero
    add(0, 1,7,0,32'hFFFF, 0,0,0,0, 0,  1,7,0,0, 0,0, "rd0_push");
    add(0, 0,0,0,0,        0,0,0,0, 1,  0,0,0,0, 0,0, "rd0_pop");

    // Fill to full, head held, stall at 6, ninth push dropped
    for (int i = 1; i <= 8; i++)
      add(0, 1,4'(i),5'(i),32'(32'h100+i), 0,0,0,0, 0,  1,1,1,32'h101, (i >= 6),0, "fill");
    add(0, 1,9,9,32'h109, 0,0,0,0, 0,  1,1,1,32'h101, 1,1, "overflow_drop");
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        add(0, 0,0,0,0, 0,0,0,0, 1,  1,4'(k+1),5'(k+1),32'(32'h100+k+1), (8-k >= 6),1, "drain_full");
      else
        add(0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,0, 0,1, "drain_empty");
    end

    // Full FIFO with simultaneous pop and push, pointers wrap
    add(1, 0,0,0,0, 0,0,0,0, 0,  0,0,0,0, 0,0, "reset2");
    for (int i = 0; i < 8; i++)
      add(0, 1,wp(i),wr(i),wv(i), 0,0,0,0, 0,  1,wp(0),wr(0),wv(0), (i+1 >= 6),0, "wrap_fill");
    for (int j = 0; j < 12; j++)
      add(0, 1,wp(8+j),wr(8+j),wv(8+j), 0,0,0,0, 1,  1,wp(j+1),wr(j+1),wv(j+1), 1,0, "wrap_pushpop");
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        add(0, 0,0,0,0, 0,0,0,0, 1,  1,wp(12+k),wr(12+k),wv(12+k), (8-k >= 6),0, "wrap_drain");
      else
        add(0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,0, 0,0, "wrap_empty");
    end

    // One slot left, dual push: ALU kept, LS dropped
    add(1, 0,0,0,0, 0,0,0,0, 0,  0,0,0,0, 0,0, "reset3");
    for (int i = 0; i < 7; i++)
      add(0, 1,4'(i),5'(i+1),32'(32'h300+i), 0,0,0,0, 0,  1,0,1,32'h300, (i+1 >= 6),0, "one_slot_fill");
    add(0, 1,7,8,32'h307, 1,9,9,32'h399, 0,  1,0,1,32'h300, 1,1, "one_slot_dual");
    for (int k = 1; k <= 8; k++) begin
      if (k < 8)
        add(0, 0,0,0,0, 0,0,0,0, 1,  1,4'(k),5'(k+1),32'(32'h300+k), (8-k >= 6),1, "one_slot_drain");
      else
        add(0, 0,0,0,0, 0,0,0,0, 1,  0,0,0,0, 0,1, "one_slot_empty");
    end

    // Reset mid-operation with a valid input in the reset cycle
    for (int i = 1; i <= 3; i++)
      add(0, 1,4'(i),5'(i),32'(32'h400+i), 0,0,0,0, 0,  1,1,1,32'h401, 0,1, "pre_reset_fill");
    add(1, 1,5,5,32'h555, 0,0,0,0, 0,  0,0,0,0, 0,0, "mid_reset");
    add(0, 0,0,0,0,       0,0,0,0, 1,  0,0,0,0, 0,0, "post_reset_idle");

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      alu_valid = vecs[i].av;  alu_pos = vecs[i].ap; alu_rd = vecs[i].ar; alu_value = vecs[i].aval;
      ls_valid  = vecs[i].lv;  ls_pos  = vecs[i].lp; ls_rd  = vecs[i].lr; ls_value  = vecs[i].lval;
      out_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check({vecs[i].nm, ".out_valid"}, i, 32'(out_valid), 32'(vecs[i].ev));
      check({vecs[i].nm, ".out_pos"},   i, 32'(out_pos),   32'(vecs[i].ep));
      check({vecs[i].nm, ".out_rd"},    i, 32'(out_rd),    32'(vecs[i].er));
      check({vecs[i].nm, ".out_value"}, i, out_value,      vecs[i].evl);
      check({vecs[i].nm, ".stall"},     i, 32'(stall),     32'(vecs[i].es));
      check({vecs[i].nm, ".overflow"},  i, 32'(overflow),  32'(vecs[i].eo));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
